// File: rtl/assert_event_arbiter.sv
// Collects checker fail pulses into saturating per-source counters and reports
// them one source at a time over a valid/ready channel with round-robin fairness.
module assert_event_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int CNT_W   = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clear,
    input  logic [NUM_SRC-1:0] fail,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [ID_W-1:0]    rpt_id,
    output logic [CNT_W-1:0]   rpt_count,
    output logic               rpt_sat,
    output logic [NUM_SRC-1:0] pending,
    output logic               first_valid,
    output logic [ID_W-1:0]    first_id,
    output logic               overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {ST_EMPTY, ST_FULL} rpt_state_t;

    rpt_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q   [NUM_SRC];
    logic [CNT_W-1:0]   cnt_d   [NUM_SRC];
    logic [CNT_W-1:0]   cnt_inc [NUM_SRC];
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] hit, ovf_hit, req;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    rpt_id_q, rpt_id_d;
    logic [CNT_W-1:0]   rpt_count_q, rpt_count_d;
    logic               rpt_sat_q, rpt_sat_d;
    logic               first_valid_q, first_valid_d;
    logic [ID_W-1:0]    first_id_q, first_id_d;
    logic               overflow_q, overflow_d;
    logic [ID_W-1:0]    gnt_id, first_lo;
    logic               gnt_found, slot_free, grant;

    assign hit       = en ? fail : '0;
    // Same-cycle hits are eligible so an idle arbiter reports with one cycle latency.
    assign req       = pending_q | hit;
    assign slot_free = (state_q == ST_EMPTY) || rpt_ready;
    assign grant     = slot_free && gnt_found;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic granted;
            assign granted       = grant && (gnt_id == ID_W'(gi));
            assign cnt_inc[gi]   = !hit[gi] ? cnt_q[gi] :
                                   (cnt_q[gi] == CNT_MAX) ? CNT_MAX : cnt_q[gi] + CNT_W'(1);
            assign ovf_hit[gi]   = hit[gi] && (cnt_q[gi] == CNT_MAX);
            assign cnt_d[gi]     = granted ? '0 : cnt_inc[gi];
            assign pending_d[gi] = granted ? 1'b0 : req[gi];
        end
    endgenerate

    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_q) + k) % NUM_SRC;
            if (!gnt_found && req[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        first_lo = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (hit[k]) begin
                first_lo = ID_W'(k);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        rpt_id_d      = rpt_id_q;
        rpt_count_d   = rpt_count_q;
        rpt_sat_d     = rpt_sat_q;
        first_valid_d = first_valid_q;
        first_id_d    = first_id_q;
        overflow_d    = overflow_q | (|ovf_hit);
        if (slot_free) begin
            if (gnt_found) begin
                state_d     = ST_FULL;
                rpt_id_d    = gnt_id;
                rpt_count_d = cnt_inc[gnt_id];
                rpt_sat_d   = (cnt_inc[gnt_id] == CNT_MAX);
                rr_d        = (gnt_id == ID_W'(NUM_SRC - 1)) ? '0 : gnt_id + ID_W'(1);
            end else begin
                state_d = ST_EMPTY;
            end
        end
        if (!first_valid_q && (|hit)) begin
            first_valid_d = 1'b1;
            first_id_d    = first_lo;
        end
    end

    // clear behaves exactly like reset, including dropping a held report.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q       <= ST_EMPTY;
            pending_q     <= '0;
            rr_q          <= '0;
            rpt_id_q      <= '0;
            rpt_count_q   <= '0;
            rpt_sat_q     <= 1'b0;
            first_valid_q <= 1'b0;
            first_id_q    <= '0;
            overflow_q    <= 1'b0;
            for (int k = 0; k < NUM_SRC; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            rr_q          <= rr_d;
            rpt_id_q      <= rpt_id_d;
            rpt_count_q   <= rpt_count_d;
            rpt_sat_q     <= rpt_sat_d;
            first_valid_q <= first_valid_d;
            first_id_q    <= first_id_d;
            overflow_q    <= overflow_d;
            for (int k = 0; k < NUM_SRC; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign rpt_valid   = (state_q == ST_FULL);
    assign rpt_id      = rpt_id_q;
    assign rpt_count   = rpt_count_q;
    assign rpt_sat     = rpt_sat_q;
    assign pending     = pending_q;
    assign first_valid = first_valid_q;
    assign first_id    = first_id_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/assert_event_arbiter.md
Name: assert_event_arbiter

Overview:
- Collects single-cycle failure pulses from up to NUM_SRC in-design assertion/condition checkers.
- Coalesces repeated hits per source into saturating counters.
- Reports them one at a time over a valid/ready channel, with round-robin fairness between sources.
- Sits between the checker primitives and the debug/CSR error-log path; also latches the first failing source since the last clear.

Parameters:
- NUM_SRC, 8, number of checker inputs (2..32).
- CNT_W, 8, width of per-source hit counter and reported count.
- ID_W, $clog2(NUM_SRC), width of source index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  capture enable; when 0, new fail pulses are ignored, reporting continues.
- clear  in  1  synchronous clear of all pending state, counters, first-fail capture, overflow.
- fail  in  NUM_SRC  per-source failure pulse; one hit per cycle per bit while high.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  consumer accepts report.
- rpt_id  out  ID_W  source index of report.
- rpt_count  out  CNT_W  hits coalesced for that source (1..2^CNT_W-1).
- rpt_sat  out  1  count saturated for this report.
- pending  out  NUM_SRC  per-source sticky "hits not yet reported".
- first_valid  out  1  a failure has been captured since reset/clear.
- first_id  out  ID_W  lowest-index source failing in the first failing cycle.
- overflow  out  1  sticky: a counter saturated since reset/clear.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0; pending=0, counters=0, RR pointer=0, report register empty. rst has priority over clear.
- clear: same effect as reset except behaviour is identical; any held report is dropped (rpt_valid=0 next cycle). clear has priority over fail in the same cycle.
- Capture: on each posedge with en=1 and fail[i]=1:
  - cnt[i] increments, saturating at 2^CNT_W-1.
  - pending[i] is set.
  - When an increment is attempted at saturation, overflow is set and remains set.
- First-fail: when first_valid=0 and any captured fail bit is 1, set first_valid=1 and first_id=lowest set index. Hold until clear/rst.
- Report register states:
  - EMPTY: rpt_valid=0.
  - FULL: rpt_valid=1.
- Grant condition: a grant occurs when the register is EMPTY, or FULL with rpt_ready=1 (same-cycle refill, full throughput: one report per cycle).
- Grant selection: the first pending source at or after the RR pointer, wrapping at NUM_SRC-1 to 0.
- Effects of a grant to source g:
  - Load rpt_id=g.
  - Load rpt_count=cnt[g], or cnt[g]+1 if a fail on g is captured in the same cycle (saturating).
  - Load rpt_sat=1 if the loaded count is saturated.
  - Clear cnt[g] and pending[g].
  - RR pointer = g+1 mod NUM_SRC.
  - Latency: fail pulse at cycle N with register EMPTY gives rpt_valid=1 at cycle N+1.
- Simultaneous grant and fail on g: the hit is included in the report and does not leave pending[g] set. A fail on g in the cycle after the grant starts a new count of 1.
- No pending sources while FULL and rpt_ready=1: register goes EMPTY next cycle.
- rpt_valid=1 with rpt_ready=0: rpt_id, rpt_count and rpt_sat are held stable. Hits keep accumulating in cnt.
- rpt_valid never drops without a handshake, except on rst/clear.
- The pending output reflects registered state. It excludes the source currently held in the report register unless that source has had new hits.

Test Plan:
- Single hit: rst, en=1, fail=8'h04 for 1 cycle, rpt_ready=1 -> next cycle rpt_valid=1, rpt_id=2, rpt_count=1; then rpt_valid=0; first_valid=1, first_id=2.
- Coalescing under backpressure: rpt_ready=0, fail[5] high 10 cycles -> first report id=5 count=1 held stable. Raise ready -> second report id=5 count=9, rpt_sat=0.
- Round-robin: fail=8'hFF for 1 cycle, ready=1 -> reports id 0,1,...,7 on consecutive cycles, count=1 each. Then fail=8'h81 -> id 0 then 7 (pointer at 0 after wrap).
- Saturation (CNT_W=4): rpt_ready=0, fail[3] held 20 cycles -> overflow=1. The queued report after the first shows count=15, rpt_sat=1.
- Simultaneous grant/fail: pending[1] with count=3, ready=1 and fail[1] pulse in the grant cycle -> report count=4, pending[1]=0 afterwards.
- Clear and reset mid-report: report held (ready=0), assert clear together with fail=8'h01 -> next cycle rpt_valid=0, pending=0, first_valid=0, overflow=0, fail ignored. Repeat with rst -> same result. en=0 with fail=8'hFF -> no state change.
